// File: rtl/ltl_nfa_engine.sv
// ltl_nfa_engine: runtime-programmable homogeneous NFA (STE array) for LTL monitoring.
// Optional sticky report vector with rpt_clear: define LTL_NFA_STICKY_REPORT_EN.
module ltl_nfa_engine #(
    parameter int N_STE = 16,
    parameter int SYM_W = 8,
    parameter int CNT_W = 16,
    localparam int IDX_W = (N_STE > 1) ? $clog2(N_STE) : 1,
    localparam int WW = (SYM_W > 5) ? SYM_W - 5 : 1,
    localparam int NW = 1 << (SYM_W - 5)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_type,
    input  logic [IDX_W-1:0] cfg_ste,
    input  logic [WW-1:0]    cfg_word,
    input  logic [31:0]      cfg_data,
    input  logic             start,
    input  logic             stop,
    input  logic             sym_valid,
    input  logic [SYM_W-1:0] symbol,
    output logic             running,
    output logic [N_STE-1:0] active,
    output logic [N_STE-1:0] report_vec,
    output logic             report_any,
    output logic [CNT_W-1:0] report_cnt,
    output logic             first_rpt_valid,
`ifdef LTL_NFA_STICKY_REPORT_EN
    input  logic             rpt_clear,
    output logic [N_STE-1:0] sticky_rpt,
`endif
    output logic [CNT_W-1:0] first_rpt_idx
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t r_state, w_state_nxt;

    logic [31:0]      r_match [N_STE][NW];
    logic [N_STE-1:0] r_adj [N_STE];
    logic [N_STE-1:0] r_sod, r_allin, r_rep;
    logic [N_STE-1:0] r_active, w_active_nxt;
    logic             r_first, r_fresh, r_first_vld;
    logic [CNT_W-1:0] r_idx, r_cnt, r_first_idx;
    logic             w_go, w_halt, w_accept, w_cfg_we, w_fresh_rpt;
    logic [WW-1:0]    w_sym_word;
    logic [4:0]       w_sym_bit;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start && !stop) w_state_nxt = S_RUN;
            S_RUN:   if (stop) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        running   = (r_state == S_RUN);
        cfg_ready = (r_state == S_IDLE);
    end

    assign w_go       = cfg_ready && start && !stop;
    assign w_halt     = running && stop;
    assign w_accept   = running && !stop && sym_valid;
    assign w_cfg_we   = cfg_valid && cfg_ready;
    assign w_sym_word = WW'(symbol >> 5);
    assign w_sym_bit  = symbol[4:0];

    always_comb begin
        w_active_nxt = '0;
        for (int i = 0; i < N_STE; i++) begin
            w_active_nxt[i] = ((|(r_active & r_adj[i])) || (r_sod[i] && r_first) || r_allin[i])
                              && r_match[i][w_sym_word][w_sym_bit];
        end
    end

    // Decode by STE number so an out-of-range cfg_ste leaves storage untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_STE; i++) begin
                r_adj[i] <= '0;
                for (int w = 0; w < NW; w++) r_match[i][w] <= '0;
            end
            r_sod   <= '0;
            r_allin <= '0;
            r_rep   <= '0;
        end else if (w_cfg_we) begin
            for (int i = 0; i < N_STE; i++) begin
                if (cfg_ste == IDX_W'(i)) begin
                    case (cfg_type)
                        2'd0: r_match[i][cfg_word] <= cfg_data;
                        2'd1: r_adj[i] <= cfg_data[N_STE-1:0];
                        2'd2: begin
                            r_sod[i]   <= cfg_data[0];
                            r_allin[i] <= cfg_data[1];
                            r_rep[i]   <= cfg_data[2];
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_active <= '0;
            r_idx    <= '0;
            r_first  <= 1'b0;
            r_fresh  <= 1'b0;
        end else if (w_go) begin
            r_active <= '0;
            r_idx    <= '0;
            r_first  <= 1'b1;
            r_fresh  <= 1'b0;
        end else if (w_halt) begin
            r_active <= '0;
            r_fresh  <= 1'b0;
        end else if (w_accept) begin
            r_active <= w_active_nxt;
            r_idx    <= r_idx + CNT_W'(1);
            r_first  <= 1'b0;
            r_fresh  <= 1'b1;
        end else begin
            r_fresh  <= 1'b0;
        end
    end

    assign report_vec  = r_active & r_rep;
    assign report_any  = |report_vec;
    assign w_fresh_rpt = running && r_fresh && report_any;

    // r_idx has already advanced past the reporting symbol.
    always_ff @(posedge clk) begin
        if (reset || w_go) begin
            r_cnt       <= '0;
            r_first_vld <= 1'b0;
            r_first_idx <= '0;
        end else if (w_fresh_rpt) begin
            if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
            if (!r_first_vld) begin
                r_first_vld <= 1'b1;
                r_first_idx <= r_idx - CNT_W'(1);
            end
        end
    end

    assign active          = r_active;
    assign report_cnt      = r_cnt;
    assign first_rpt_valid = r_first_vld;
    assign first_rpt_idx   = r_first_idx;

`ifdef LTL_NFA_STICKY_REPORT_EN
    logic [N_STE-1:0] r_sticky;

    always_ff @(posedge clk) begin
        if (reset || w_go || rpt_clear) r_sticky <= '0;
        else if (running && r_fresh)    r_sticky <= r_sticky | report_vec;
    end

    assign sticky_rpt = r_sticky;
`endif

endmodule

// File: tb/tb_ltl_nfa_engine.sv
// tb_ltl_nfa_engine: vector table, directed corner sequences and a random run
// compared cycle by cycle with a spec-level NFA model (N_STE=4, SYM_W=8, CNT_W=4).
module tb_ltl_nfa_engine;
    localparam int N = 4, SW = 8, CW = 4, CMAX = 15;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cfg_valid = 1'b0, cfg_ready;
    logic [1:0] cfg_type = '0;
    logic [1:0] cfg_ste = '0;
    logic [2:0] cfg_word = '0;
    logic [31:0] cfg_data = '0;
    logic start = 1'b0, stop = 1'b0, sym_valid = 1'b0;
    logic [SW-1:0] symbol = '0;
    logic running, report_any, first_rpt_valid;
    logic [N-1:0] active, report_vec;
    logic [CW-1:0] report_cnt, first_rpt_idx;
`ifdef LTL_NFA_STICKY_REPORT_EN
    logic rpt_clear = 1'b0;
    logic [N-1:0] sticky_rpt;
`endif

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    ltl_nfa_engine #(.N_STE(N), .SYM_W(SW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_type(cfg_type),
        .cfg_ste(cfg_ste), .cfg_word(cfg_word), .cfg_data(cfg_data),
        .start(start), .stop(stop), .sym_valid(sym_valid), .symbol(symbol),
        .running(running), .active(active), .report_vec(report_vec),
        .report_any(report_any), .report_cnt(report_cnt),
        .first_rpt_valid(first_rpt_valid),
`ifdef LTL_NFA_STICKY_REPORT_EN
        .rpt_clear(rpt_clear), .sticky_rpt(sticky_rpt),
`endif
        .first_rpt_idx(first_rpt_idx)
    );

    // Reference model: match sets as a plain symbol-indexed bit table.
    bit mm [N][256];
    bit [N-1:0] madj [N];
    bit [N-1:0] msod, mall, mrep, mact, mstk;
    bit mrun, mfirst, mfresh, mfv;
    int midx, mlast, mcnt, mfidx;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            madj[i] = '0;
            for (int s = 0; s < 256; s++) mm[i][s] = 1'b0;
        end
        msod = '0; mall = '0; mrep = '0; mact = '0; mstk = '0;
        mrun = 0; mfirst = 0; mfresh = 0; mfv = 0;
        midx = 0; mlast = 0; mcnt = 0; mfidx = 0;
    endfunction

    function automatic void mstep();
        bit rpt;
        bit en;
        bit [N-1:0] nact;
        if (reset) begin
            model_reset();
            return;
        end
        rpt = mrun && mfresh && ((mact & mrep) != 0);
        if (rpt) begin
            if (mcnt < CMAX) mcnt++;
            if (!mfv) begin
                mfv = 1;
                mfidx = mlast;
            end
        end
`ifdef LTL_NFA_STICKY_REPORT_EN
        if (rpt_clear || (!mrun && start && !stop)) mstk = '0;
        else if (mrun && mfresh) mstk |= mact & mrep;
`endif
        if (cfg_valid && !mrun) begin
            case (cfg_type)
                2'd0: for (int b = 0; b < 32; b++) mm[cfg_ste][int'(cfg_word) * 32 + b] = cfg_data[b];
                2'd1: madj[cfg_ste] = cfg_data[N-1:0];
                2'd2: begin
                    msod[cfg_ste] = cfg_data[0];
                    mall[cfg_ste] = cfg_data[1];
                    mrep[cfg_ste] = cfg_data[2];
                end
                default: ;
            endcase
        end
        if (mrun && stop) begin
            mrun = 0; mact = '0; mfresh = 0;
        end else if (!mrun && start && !stop) begin
            mrun = 1; mact = '0; mcnt = 0; midx = 0; mfv = 0; mfirst = 1; mfresh = 0;
        end else if (mrun && sym_valid) begin
            for (int i = 0; i < N; i++) begin
                en = ((mact & madj[i]) != 0) || (msod[i] && mfirst) || mall[i];
                nact[i] = en && mm[i][symbol];
            end
            mact = nact;
            mlast = midx;
            midx = (midx + 1) % (CMAX + 1);
            mfirst = 0;
            mfresh = 1;
        end else begin
            mfresh = 0;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("m_cfg_ready", 32'(cfg_ready), 32'(!mrun));
        chk("m_running", 32'(running), 32'(mrun));
        chk("m_active", 32'(active), 32'(mact));
        chk("m_report_vec", 32'(report_vec), 32'(mact & mrep));
        chk("m_report_any", 32'(report_any), 32'((mact & mrep) != 0));
        chk("m_report_cnt", 32'(report_cnt), 32'(mcnt));
        chk("m_first_valid", 32'(first_rpt_valid), 32'(mfv));
        if (mfv) chk("m_first_idx", 32'(first_rpt_idx), 32'(mfidx));
`ifdef LTL_NFA_STICKY_REPORT_EN
        chk("m_sticky", 32'(sticky_rpt), 32'(mstk));
`endif
    endtask

    task automatic cyc();
        @(posedge clk);
        mstep();
        #1;
        check_all();
    endtask

    task automatic gap(input int n);
        repeat (n) cyc();
    endtask

    task automatic sym_in(input logic [7:0] s);
        sym_valid = 1; symbol = s;
        cyc();
        sym_valid = 0;
    endtask

    task automatic pulse_start();
        start = 1; cyc(); start = 0;
    endtask

    task automatic pulse_stop();
        stop = 1; cyc(); stop = 0;
    endtask

    task automatic cfgw(input logic [1:0] t, input logic [1:0] s, input logic [2:0] w, input logic [31:0] d);
        cfg_valid = 1; cfg_type = t; cfg_ste = s; cfg_word = w; cfg_data = d;
        cyc();
        cfg_valid = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        gap(2);
        reset = 0;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_running"}, 32'(running), 0);
        chk({tag, "_cfg_ready"}, 32'(cfg_ready), 1);
        chk({tag, "_active"}, 32'(active), 0);
        chk({tag, "_report_any"}, 32'(report_any), 0);
        chk({tag, "_report_cnt"}, 32'(report_cnt), 0);
        chk({tag, "_first_valid"}, 32'(first_rpt_valid), 0);
        chk({tag, "_first_idx"}, 32'(first_rpt_idx), 0);
    endtask

    task automatic prog_partition();
        cfgw(0, 0, 0, 32'h0000_FFFF);
        cfgw(0, 1, 0, 32'hFFFF_0000);
        cfgw(1, 0, 0, 32'h1);
        cfgw(1, 1, 0, 32'h1);
        cfgw(2, 0, 0, 32'h1);
        cfgw(2, 1, 0, 32'h4);
    endtask

    typedef struct {
        bit st, sp, sv;
        logic [7:0] sym;
        logic [3:0] act;
        bit rany;
        logic [3:0] cnt;
        bit fv;
        logic [3:0] fidx;
        bit run;
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{1, 0, 0, 8'h00, 4'h0, 0, 4'h0, 0, 4'h0, 1};
        tbl[1] = '{0, 0, 1, 8'h05, 4'h1, 0, 4'h0, 0, 4'h0, 1};
        tbl[2] = '{0, 0, 1, 8'h03, 4'h1, 0, 4'h0, 0, 4'h0, 1};
        tbl[3] = '{0, 0, 1, 8'h12, 4'h2, 1, 4'h0, 0, 4'h0, 1};
        tbl[4] = '{0, 0, 0, 8'h00, 4'h2, 1, 4'h1, 1, 4'h2, 1};
        tbl[5] = '{0, 0, 0, 8'h00, 4'h2, 1, 4'h1, 1, 4'h2, 1};
        tbl[6] = '{0, 0, 1, 8'h05, 4'h0, 0, 4'h1, 1, 4'h2, 1};
        tbl[7] = '{0, 1, 0, 8'h00, 4'h0, 0, 4'h1, 1, 4'h2, 0};

        model_reset();
        do_reset();
        cyc();
        reset_checks("rst");

        prog_partition();
        for (int k = 0; k < 8; k++) begin
            start = tbl[k].st; stop = tbl[k].sp;
            sym_valid = tbl[k].sv; symbol = tbl[k].sym;
            cyc();
            start = 0; stop = 0; sym_valid = 0;
            chk($sformatf("tbl%0d_active", k), 32'(active), 32'(tbl[k].act));
            chk($sformatf("tbl%0d_report_any", k), 32'(report_any), 32'(tbl[k].rany));
            chk($sformatf("tbl%0d_report_cnt", k), 32'(report_cnt), 32'(tbl[k].cnt));
            chk($sformatf("tbl%0d_first_valid", k), 32'(first_rpt_valid), 32'(tbl[k].fv));
            chk($sformatf("tbl%0d_running", k), 32'(running), 32'(tbl[k].run));
            if (tbl[k].fv) chk($sformatf("tbl%0d_first_idx", k), 32'(first_rpt_idx), 32'(tbl[k].fidx));
        end

        // Symbol gaps must not move the automaton or the index.
        pulse_start();
        sym_in(8'h05); chk("gap_act0", 32'(active), 1);
        gap(5);        chk("gap_hold", 32'(active), 1);
        sym_in(8'h03); chk("gap_act1", 32'(active), 1);
        gap(5);
        sym_in(8'h12); chk("gap_act2", 32'(active), 2);
        gap(1);
        chk("gap_cnt", 32'(report_cnt), 1);
        chk("gap_first_idx", 32'(first_rpt_idx), 2);

        // Config writes are refused while running.
        cfg_valid = 1; cfg_type = 1; cfg_ste = 1; cfg_word = 0; cfg_data = 32'hF;
        chk("run_cfg_ready", 32'(cfg_ready), 0);
        cyc();
        cfg_valid = 0;
        sym_in(8'h13);
        chk("run_adj_unchanged", 32'(active), 0);
        pulse_stop();
        chk("idle_cfg_ready", 32'(cfg_ready), 1);
        cfgw(1, 1, 0, 32'hF);
        cfgw(1, 1, 0, 32'h1);

        // All-input STE reports on every symbol; counter saturates at 15.
        cfgw(2, 2, 0, 32'h6);
        for (int w = 0; w < 8; w++) cfgw(0, 2, 3'(w), 32'hFFFF_FFFF);
        pulse_start();
        for (int k = 0; k < 10; k++) sym_in(8'($urandom));
        gap(1);
        chk("allin_cnt10", 32'(report_cnt), 10);
        chk("allin_active2", 32'(active[2]), 1);
        for (int k = 0; k < 10; k++) sym_in(8'($urandom));
        gap(1);
        chk("allin_sat", 32'(report_cnt), 15);

        // start and stop together in RUN: stop wins.
        start = 1; stop = 1;
        cyc();
        start = 0; stop = 0;
        chk("ss_running", 32'(running), 0);
        chk("ss_active", 32'(active), 0);
        chk("ss_cnt_hold", 32'(report_cnt), 15);

        // Reset mid-run erases configuration.
        pulse_start();
        sym_in(8'h07);
        reset = 1;
        cyc();
        reset = 0;
        reset_checks("midrst");
        pulse_start();
        for (int k = 0; k < 5; k++) begin
            sym_in(8'($urandom));
            chk("midrst_noact", 32'(active), 0);
        end
        gap(1);
        chk("midrst_cnt", 32'(report_cnt), 0);
        pulse_stop();

`ifdef LTL_NFA_STICKY_REPORT_EN
        prog_partition();
        pulse_start();
        sym_in(8'h05); sym_in(8'h03); sym_in(8'h12);
        gap(1);
        chk("stk_set", 32'(sticky_rpt), 2);
        sym_in(8'h05);
        gap(2);
        chk("stk_hold", 32'(sticky_rpt), 2);
        rpt_clear = 1; cyc(); rpt_clear = 0;
        chk("stk_clear", 32'(sticky_rpt), 0);
        pulse_stop();
        pulse_start();
        sym_in(8'h05); sym_in(8'h03); sym_in(8'h12);
        rpt_clear = 1; cyc(); rpt_clear = 0;
        chk("stk_clear_wins", 32'(sticky_rpt), 0);
        gap(1);
        chk("stk_stay0", 32'(sticky_rpt), 0);
        pulse_stop();
`endif

        // Random automaton and random traffic against the model.
        do_reset();
        for (int i = 0; i < N; i++) begin
            for (int w = 0; w < 8; w++) cfgw(0, 2'(i), 3'(w), $urandom);
            cfgw(1, 2'(i), 0, $urandom);
            cfgw(2, 2'(i), 0, $urandom_range(0, 7));
        end
        cfgw(3, 1, 0, 32'hFFFF_FFFF);
        for (int k = 0; k < 1500; k++) begin
            int r;
            r = $urandom_range(0, 99);
            start = (r < 4);
            stop = (r >= 97);
            sym_valid = ($urandom_range(0, 9) < 7);
            symbol = 8'($urandom);
            cfg_valid = ($urandom_range(0, 29) == 0);
            cfg_type = 2'($urandom);
            cfg_ste = 2'($urandom);
            cfg_word = 3'($urandom);
            cfg_data = $urandom;
`ifdef LTL_NFA_STICKY_REPORT_EN
            rpt_clear = ($urandom_range(0, 19) == 0);
`endif
            cyc();
        end
        start = 0; stop = 0; sym_valid = 0; cfg_valid = 0;
`ifdef LTL_NFA_STICKY_REPORT_EN
        rpt_clear = 0;
`endif
        gap(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ltl_nfa_engine.md
Name: ltl_nfa_engine

Overview:
- Runtime-programmable homogeneous NFA (STE array) for LTL runtime monitoring; one symbol per cycle.
- Replaces per-property hardwired automata: STE count and symbol width are parameters; match sets, transitions, start and report attributes are loaded through a config port.
- Sits between the trace symbol encoder and the monitor report aggregator.
- Adds a run/idle FSM, symbol valid gating, a report counter and first-report capture.

Parameters:
- N_STE, 16, number of STEs (2..32).
- SYM_W, 8, symbol width; match row = 2^SYM_W bits (SYM_W 5..10).
- CNT_W, 16, report counter and symbol index width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config write accepted; high only in IDLE.
- cfg_type  in  2  0 = match word, 1 = adjacency row, 2 = attributes, 3 = reserved (ignored).
- cfg_ste  in  clog2(N_STE)  target STE.
- cfg_word  in  SYM_W-5  32-bit word index within a match row.
- cfg_data  in  32  write data.
- start  in  1  IDLE->RUN request.
- stop  in  1  RUN->IDLE request.
- sym_valid  in  1  symbol present this cycle.
- symbol  in  SYM_W  input symbol.
- running  out  1  FSM in RUN.
- active  out  N_STE  registered active-state vector.
- report_vec  out  N_STE  active & report_mask.
- report_any  out  1  OR of report_vec.
- report_cnt  out  CNT_W  symbols with report_any, saturating.
- first_rpt_valid  out  1  first report captured since start.
- first_rpt_idx  out  CNT_W  symbol index of first report; 0-based from start.

Behaviour:
- Reset: FSM IDLE; all match, adjacency and attribute storage cleared; every output 0 except cfg_ready = 1.
- Config: write occurs when cfg_valid & cfg_ready, taking one cycle. cfg_ready = (state == IDLE).
  - Type 0 writes match[cfg_ste][cfg_word*32 +: 32].
  - Type 1 writes adj[cfg_ste][N_STE-1:0] = cfg_data[N_STE-1:0]. Bit j set means edge j->cfg_ste.
  - Type 2 writes attributes: bit0 start-of-data, bit1 all-input start, bit2 report.
  - Out-of-range cfg_ste or cfg_type 3: handshake still completes, no storage change.
- FSM states are IDLE and RUN.
  - IDLE -> RUN on start. On entry: active, report_cnt, symbol index and first_rpt_valid cleared; first flag set.
  - RUN -> IDLE on stop. active is cleared the same edge. report_cnt and first_rpt hold until the next start.
  - start and stop together: stop wins. start in RUN and stop in IDLE are ignored.
  - running = 1 in RUN.
- STE update, RUN only, on sym_valid:
  - en[i] = |(active & adj[i]) | (sod[i] & first) | allin[i].
  - active_next[i] = en[i] & match[i][symbol].
  - first clears after the first accepted symbol.
  - No update when sym_valid = 0, so symbol gaps are invisible to the automaton.
  - Latency: active reflects a symbol on the edge after it is accepted.
- report_vec and report_any are combinational from registered active.
- Index, counter and first-report capture:
  - The symbol index increments per accepted symbol and wraps at 2^CNT_W.
  - report_cnt increments on each cycle where report_any is high in RUN and that active value came from a fresh update. It saturates at all-ones.
  - first_rpt_idx latches the index of the symbol that produced the first report; first_rpt_valid is set with it.
- Reset mid-run: returns to IDLE and erases configuration.

Optional Feature:
- Macro: LTL_NFA_STICKY_REPORT_EN.
- Defined: adds input rpt_clear (1 bit) and output sticky_rpt (N_STE).
  - sticky_rpt |= report_vec on each fresh update.
  - rpt_clear zeroes sticky_rpt; it wins over a simultaneous set.
  - Also cleared on reset and on start.
- Undefined: neither port exists and no sticky logic is present.

Test Plan:
- Config handshake: in RUN, drive cfg_valid with cfg_type 1 -> cfg_ready = 0 and adj unchanged. Issue stop, rewrite -> accepted in 1 cycle.
- Partition automaton (N_STE = 4):
  - Setup: STE0 sod+self-loop, match 0x00-0x0F; STE1 edge from STE0, match 0x10-0x1F, report.
  - Stimulus: start, then symbols 0x05, 0x03, 0x12 -> active = 0001, 0001, 0010; report_any on 3rd update; first_rpt_idx = 2; report_cnt = 1.
- Gaps: same program with sym_valid low for 5 cycles between symbols -> identical active sequence; index advances only 3.
- All-input start:
  - Setup: STE2 allin, match all 256 symbols, report.
  - Stimulus: 10 symbols -> report_cnt = 10.
  - Saturation: with CNT_W = 4, 20 symbols -> report_cnt = 15.
- start and stop asserted together in RUN -> IDLE, active = 0. Reset during RUN -> cfg storage reads back as unmatched (no activations after restart).
- Sticky (macro on): report on symbol 2, then no reports -> sticky_rpt holds. rpt_clear pulse -> 0. rpt_clear coincident with a report -> 0.
